// File: rtl/filter_p2s3.sv
// Output serializer for the 3-way parallel FIR: buffers triplets in a FIFO and
// replays them as lane 0, 1, 2 on a single valid/ready stream.
module filter_p2s3 #(
   parameter int unsigned NB    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NB-1:0]           DIN0,
   input  logic [NB-1:0]           DIN1,
   input  logic [NB-1:0]           DIN2,
   input  logic                    VIN,
   output logic [NB-1:0]           DOUT,
   output logic                    VOUT,
   input  logic                    READY,
   output logic [1:0]              IDX,
   output logic [$clog2(DEPTH):0]  COUNT,
   output logic                    OVF
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      LANE0 = 2'd0,
      LANE1 = 2'd1,
      LANE2 = 2'd2
   } lane_t;

   logic [3*NB-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [AW:0]     count;
   logic            ovf;
   lane_t           sel;
   lane_t           sel_next;
   logic [3*NB-1:0] head;
   logic            vout;
   logic            xfer;
   logic            pop;
   logic            push;
   logic            drop;

   assign vout = (count != '0);
   assign xfer = vout & READY;
   assign pop  = xfer & (sel == LANE2);
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push = VIN & ((count != FULL) | pop);
   assign drop = VIN & ~push;

   always_comb begin
      sel_next = sel;
      if (xfer) begin
         case (sel)
            LANE0:   sel_next = LANE1;
            LANE1:   sel_next = LANE2;
            LANE2:   sel_next = LANE0;
            default: sel_next = LANE0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sel <= LANE0;
      end else begin
         sel <= sel_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) begin
            mem[wptr] <= {DIN2, DIN1, DIN0};
            wptr      <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop) begin
            ovf <= 1'b1;
         end
      end
   end

   always_comb begin
      head = mem[rptr];
      DOUT = '0;
      case (sel)
         LANE0:   DOUT = head[NB-1:0];
         LANE1:   DOUT = head[2*NB-1:NB];
         LANE2:   DOUT = head[3*NB-1:2*NB];
         default: DOUT = '0;
      endcase
   end

   assign VOUT  = vout;
   assign IDX   = sel;
   assign COUNT = count;
   assign OVF   = ovf;

endmodule

// File: tb/tb_filter_p2s3.sv
// Scoreboard bench for filter_p2s3: expected samples are queued when a triplet
// is driven and compared by a monitor as the DUT hands them over.
module tb_filter_p2s3;

   localparam int unsigned NB    = 8;
   localparam int unsigned DEPTH = 4;

   logic          CLK;
   logic          RST;
   logic [NB-1:0] DIN0, DIN1, DIN2;
   logic          VIN;
   logic [NB-1:0] DOUT;
   logic          VOUT;
   logic          READY;
   logic [1:0]    IDX;
   logic [2:0]    COUNT;
   logic          OVF;

   filter_p2s3 #(.NB(NB), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .DIN0(DIN0), .DIN1(DIN1), .DIN2(DIN2), .VIN(VIN),
      .DOUT(DOUT), .VOUT(VOUT), .READY(READY), .IDX(IDX),
      .COUNT(COUNT), .OVF(OVF)
   );

   int checks = 0;
   int errors = 0;
   int n_xfer = 0;
   logic [NB+1:0] sb [$];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Monitor: every accepted sample is matched against the queue head.
   always @(negedge CLK) begin
      logic [NB+1:0] exp;
      if (!RST && VOUT === 1'b1 && READY === 1'b1) begin
         n_xfer++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: got idx %0d dout %0d, required no output",
                     IDX, $signed(DOUT));
         end else begin
            exp = sb.pop_front();
            if ({IDX, DOUT} !== exp) begin
               errors++;
               $display("FAIL sample: got idx %0d dout %0d, required idx %0d dout %0d",
                        IDX, $signed(DOUT), exp[NB+1:NB], $signed(exp[NB-1:0]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST   = 1'b1;
      VIN   = 1'b0;
      READY = 1'b0;
      repeat (2) tick();
      RST = 1'b0;
      sb.delete();
   endtask

   task automatic push_triplet(input logic [NB-1:0] a, input logic [NB-1:0] b,
                               input logic [NB-1:0] c, input bit acc);
      DIN0 = a;
      DIN1 = b;
      DIN2 = c;
      VIN  = 1'b1;
      if (acc) begin
         sb.push_back({2'd0, a});
         sb.push_back({2'd1, b});
         sb.push_back({2'd2, c});
      end
      tick();
      VIN = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while (sb.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d samples pending, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({VOUT, IDX, COUNT, OVF, DOUT} !== {1'b0, 2'd0, 3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_values: got vout %b idx %0d count %0d ovf %b dout %h, required 0 0 0 0 00",
                  VOUT, IDX, COUNT, OVF, DOUT);
      end
   endtask

   task automatic test_single();
      int nv = 0;
      apply_reset();
      READY = 1'b1;
      tick();
      checks++;
      if (VOUT !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: got vout %b, required 0", VOUT);
      end
      push_triplet(8'd10, NB'(-20), 8'd35, 1'b1);
      checks++;
      if (VOUT !== 1'b1 || IDX !== 2'd0) begin
         errors++;
         $display("FAIL single_latency: got vout %b idx %0d, required 1 0", VOUT, IDX);
      end
      for (int i = 0; i < 6; i++) begin
         if (VOUT === 1'b1) nv++;
         tick();
      end
      checks++;
      if (nv != 3) begin
         errors++;
         $display("FAIL single_vout_cycles: got %0d, required 3", nv);
      end
      checks++;
      if (COUNT !== 3'd0 || OVF !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL single_end: got count %0d ovf %b pending %0d, required 0 0 0",
                  COUNT, OVF, sb.size());
      end
   endtask

   task automatic test_backpressure();
      bit            seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [NB-1:0] vals [3];
      int            exp_idx = 0;
      vals[0] = 8'd10;
      vals[1] = NB'(-20);
      vals[2] = 8'd35;
      apply_reset();
      push_triplet(vals[0], vals[1], vals[2], 1'b1);
      for (int i = 0; i < 6; i++) begin
         READY = seq[i];
         checks++;
         if (IDX !== 2'(exp_idx) || DOUT !== vals[exp_idx]) begin
            errors++;
            $display("FAIL bp_hold step %0d: got idx %0d dout %0d, required idx %0d dout %0d",
                     i, IDX, $signed(DOUT), exp_idx, $signed(vals[exp_idx]));
         end
         if (seq[i]) exp_idx++;
         tick();
      end
      READY = 1'b0;
      checks++;
      if (VOUT !== 1'b0 || COUNT !== 3'd0) begin
         errors++;
         $display("FAIL bp_end: got vout %b count %0d, required 0 0", VOUT, COUNT);
      end
   endtask

   task automatic test_burst();
      int n0;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         push_triplet(NB'(i*10 + 1), NB'(i*10 + 2), NB'(-(i*10 + 3)), 1'b1);
      end
      checks++;
      if (COUNT !== 3'd4 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL burst_full: got count %0d ovf %b, required 4 0", COUNT, OVF);
      end
      push_triplet(8'd99, 8'd98, 8'd97, 1'b0);
      checks++;
      if (COUNT !== 3'd4 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL burst_overflow: got count %0d ovf %b, required 4 1", COUNT, OVF);
      end
      n0 = n_xfer;
      READY = 1'b1;
      wait_drain(40);
      tick();
      checks++;
      if (n_xfer - n0 != 12 || VOUT !== 1'b0 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL burst_drain: got %0d samples vout %b ovf %b, required 12 0 1",
                  n_xfer - n0, VOUT, OVF);
      end
      READY = 1'b0;
   endtask

   task automatic test_push_pop_full();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         push_triplet(NB'(40 + i), NB'(50 + i), NB'(60 + i), 1'b1);
      end
      READY = 1'b1;
      tick();
      tick();
      checks++;
      if (IDX !== 2'd2 || COUNT !== 3'd4) begin
         errors++;
         $display("FAIL pp_setup: got idx %0d count %0d, required 2 4", IDX, COUNT);
      end
      push_triplet(8'd77, NB'(-77), 8'd127, 1'b1);
      checks++;
      if (COUNT !== 3'd4 || OVF !== 1'b0 || IDX !== 2'd0) begin
         errors++;
         $display("FAIL pp_full: got count %0d ovf %b idx %0d, required 4 0 0", COUNT, OVF, IDX);
      end
      wait_drain(60);
      checks++;
      if (VOUT !== 1'b0 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL pp_end: got vout %b ovf %b, required 0 0", VOUT, OVF);
      end
      READY = 1'b0;
   endtask

   task automatic test_wrap();
      int n0;
      int bad = 0;
      apply_reset();
      READY = 1'b1;
      n0 = n_xfer;
      for (int t = 0; t < 10; t++) begin
         for (int e = 0; e < 3; e++) begin
            if (e == 0) push_triplet(NB'(t*7), NB'(-(t*5)), NB'(100 + t), 1'b1);
            else tick();
            if (VOUT !== 1'b1 || COUNT > 3'd1) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_stream: got %0d gap/count violations, required 0", bad);
      end
      tick();
      checks++;
      if (n_xfer - n0 != 30 || VOUT !== 1'b0 || OVF !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL wrap_end: got %0d samples vout %b ovf %b, required 30 0 0",
                  n_xfer - n0, VOUT, OVF);
      end
      READY = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      push_triplet(8'd1, 8'd2, 8'd3, 1'b1);
      push_triplet(8'd4, 8'd5, 8'd6, 1'b1);
      READY = 1'b1;
      tick();
      checks++;
      if (IDX !== 2'd1 || COUNT !== 3'd2) begin
         errors++;
         $display("FAIL rstmid_setup: got idx %0d count %0d, required 1 2", IDX, COUNT);
      end
      RST = 1'b1;
      sb.delete();
      tick();
      RST = 1'b0;
      checks++;
      if ({VOUT, IDX, COUNT, OVF, DOUT} !== {1'b0, 2'd0, 3'd0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL rstmid_values: got vout %b idx %0d count %0d ovf %b dout %h, required 0 0 0 0 00",
                  VOUT, IDX, COUNT, OVF, DOUT);
      end
      push_triplet(NB'(-1), 8'd66, 8'd33, 1'b1);
      checks++;
      if (VOUT !== 1'b1 || IDX !== 2'd0 || DOUT !== 8'hFF) begin
         errors++;
         $display("FAIL rstmid_restart: got vout %b idx %0d dout %h, required 1 0 ff", VOUT, IDX, DOUT);
      end
      wait_drain(20);
      READY = 1'b0;
   endtask

   initial begin
      RST   = 1'b1;
      VIN   = 1'b0;
      READY = 1'b0;
      DIN0  = '0;
      DIN1  = '0;
      DIN2  = '0;
      test_reset();
      test_single();
      test_backpressure();
      test_burst();
      test_push_pop_full();
      test_wrap();
      test_reset_mid();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/filter_p2s3.md
# filter_p2s3

Output serializer for the 3-way parallel FIR filter. Each `VIN` cycle it captures one triplet `DIN0`/`DIN1`/`DIN2` (the filter's `DOUT0..2` with `VOUT`) into a small FIFO. It replays the samples one per cycle in order 0, 1, 2 on a single valid/ready stream for a serial consumer such as a result checker, DAC interface or file writer. The filter has no backpressure, so the block buffers bursts and flags any triplet it loses.

## Interface
- `NB`, default 8: sample width in bits, two's complement.
- `DEPTH`, default 4: FIFO capacity in triplets. Must be a power of two and at least 2.
- `CLK`  in  1: single clock; all logic on rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `DIN0`  in  NB: sample n, the oldest of the triplet.
- `DIN1`  in  NB: sample n+1.
- `DIN2`  in  NB: sample n+2.
- `VIN`  in  1: triplet valid, one cycle per triplet, no ready back to source.
- `DOUT`  out  NB: current serial sample.
- `VOUT`  out  1: `DOUT` valid.
- `READY`  in  1: consumer accepts `DOUT` on this edge when `VOUT`=1.
- `IDX`  out  2: lane index of `DOUT` (0, 1 or 2).
- `COUNT`  out  log2(DEPTH)+1: triplets held, including the one being drained.
- `OVF`  out  1: sticky; set when a triplet was dropped.

## Operation
- Storage: `DEPTH` entries of 3×NB bits, with write pointer, read pointer, `COUNT` register and 2-bit lane counter `sel`.
- Push: on an edge with `VIN`=1, the triplet is written at the write pointer if `COUNT` < `DEPTH` or a pop happens on the same edge. Otherwise it is dropped, `OVF` is set and no state changes.
- Serial output: `VOUT` = (`COUNT` != 0). `DOUT` = lane `sel` of the head entry. `IDX` = `sel`.
- Transfer: on an edge with `VOUT`=1 and `READY`=1:
  - `sel` < 2: `sel` increments.
  - `sel` = 2: `sel` goes to 0, the read pointer advances and the entry is freed (pop).
- `COUNT` update: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- Pointers wrap modulo `DEPTH` with no special case.
- Stall: with `READY`=0, `DOUT`, `IDX` and `sel` hold. Pushes continue until full.
- Empty: `VOUT`=0. `DOUT` value is don't-care but must not be X after reset; it drives lane `sel` of the entry at the read pointer. `READY` is ignored.
- Push into an empty FIFO: the entry becomes visible on the next cycle. There is no bypass path.
- Data is passed unchanged. No arithmetic and no width change.
- `OVF` clears only on `RST`.

## Timing
- Reset values: `VOUT`=0, `IDX`=0, `COUNT`=0, `OVF`=0, `DOUT`=0. Pointers and `sel` are 0 and storage is cleared.
- `RST` asserted mid-operation takes effect on the next edge. It discards all buffered and partially sent triplets, and any push or transfer on that edge is ignored.
- Latency: a triplet pushed at edge k gives `VOUT`=1 with `IDX`=0 after edge k, provided the FIFO was empty.
- Throughput: one sample per cycle with `READY`=1. A triplet drains in 3 cycles.
- Sustained `VIN` must average at most 1 per 3 cycles. Bursts up to `DEPTH` triplets are absorbed.
- Full with `sel`=2, `READY`=1 and `VIN`=1 on the same edge: pop and push both happen, `COUNT` stays at `DEPTH` and `OVF` stays 0.
- Full with `VIN`=1 and no pop: `OVF` goes to 1 after that edge and `COUNT` stays at `DEPTH`.

## Test plan
- Single triplet (10, −20, 35) at edge 3, `READY`=1:
  - `VOUT`=1 for exactly 3 cycles starting the cycle after edge 3.
  - `DOUT`=10, −20, 35 with `IDX`=0, 1, 2.
  - `COUNT` returns to 0 and `OVF` stays 0.
- Backpressure: one triplet buffered, `READY` toggling 1,0,0,1,0,1 → same 3 values in order; `DOUT` and `IDX` hold during the 0 cycles.
- Burst: `DEPTH`=4 triplets on consecutive edges with `READY`=0 → `COUNT`=4 and `OVF`=0. A 5th `VIN` gives `OVF`=1 with `COUNT` still 4. Releasing `READY` then yields exactly 12 samples from the first 4 triplets.
- Simultaneous push and pop at full: `COUNT`=4, `sel`=2, `READY`=1, `VIN`=1 → `COUNT` stays 4, `OVF`=0, and the new triplet comes out last.
- Wrap-around: 10 triplets at 1 per 3 cycles with `READY`=1 → 30 samples in order with no gaps after the first, `COUNT` never above 1 and `OVF`=0.
- Reset mid-stream: `RST` for 1 cycle while `IDX`=1 with 2 triplets buffered → all outputs return to reset values on the next cycle. The next pushed triplet is output starting at `IDX`=0.
